// File: rtl/counter_pkg.sv
// Shared operation encoding and priority decode for the up/down counter family.
package counter_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } counter_op_e;

  // clr beats load beats counting; inc and dec together cancel to a hold.
  function automatic counter_op_e decode_op(input logic clr, input logic load,
                                            input logic inc, input logic dec);
    if (clr)              return OP_CLR;
    else if (load)        return OP_LOAD;
    else if (inc && !dec) return OP_INC;
    else if (dec && !inc) return OP_DEC;
    else                  return OP_HOLD;
  endfunction

endpackage

// File: rtl/counter_step_alu.sv
// Combinational next-value and boundary detection for counting ops (wrap or saturate).
module counter_step_alu
  import counter_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter logic [63:0] STEP  = 64'd1
) (
  input  logic [WIDTH-1:0] q,
  input  counter_op_e      op,
  input  logic             sat,
  output logic [WIDTH-1:0] next_q,
  output logic             boundary
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  // The extra top bit is the carry (up) or borrow (down) that marks a boundary.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, q} + STEP_EXT;
  assign diff = {1'b0, q} - STEP_EXT;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    next_q   = q;
    boundary = 1'b0;
    case (op)
      OP_INC: begin
        boundary = sum[WIDTH];
        next_q   = (sum[WIDTH] && sat) ? '1 : sum[WIDTH-1:0];
      end
      OP_DEC: begin
        boundary = diff[WIDTH];
        next_q   = (diff[WIDTH] && sat) ? '0 : diff[WIDTH-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with clear, load, wrap/saturate, boundary pulse and sticky overflow.
module updown_counter
  import counter_pkg::*;
#(
  parameter int             WIDTH     = 16,
  parameter logic [63:0]    STEP      = 64'd1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             inc,
  input  logic             dec,
  input  logic             sat,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  counter_op_e      op;
  logic [WIDTH-1:0] alu_q;
  logic             alu_boundary;

  assign op = decode_op(clr, load, inc, dec);

  counter_step_alu #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_alu (
    .q        (Q),
    .op       (op),
    .sat      (sat),
    .next_q   (alu_q),
    .boundary (alu_boundary)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      Q   <= RESET_VAL;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (op)
        OP_CLR: begin
          Q   <= RESET_VAL;
          tc  <= 1'b0;
          ovf <= 1'b0;
        end
        OP_LOAD: begin
          Q  <= d;
          tc <= 1'b0;
        end
        default: begin
          Q  <= alu_q;
          tc <= alu_boundary;
          if (alu_boundary) ovf <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: a STEP=1 and a STEP=3 instance share stimulus.
module tb_updown_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr, load, inc, dec, sat;
  logic [15:0] d;
  logic [15:0] q1, q3;
  logic        tc1, tc3, ovf1, ovf3;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] q;
    logic        tc;
    logic        ovf;
    bit          sel3;
  } exp_t;

  typedef struct {
    logic        clr, load, inc, dec, sat;
    logic [15:0] d;
    logic [15:0] q;
    logic        tc, ovf;
  } stim_t;

  exp_t sb[$];

  updown_counter #(.WIDTH(16), .STEP(64'd1), .RESET_VAL(16'h0000)) dut1 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .d(d),
    .inc(inc), .dec(dec), .sat(sat), .Q(q1), .tc(tc1), .ovf(ovf1)
  );

  updown_counter #(.WIDTH(16), .STEP(64'd3), .RESET_VAL(16'h0000)) dut3 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .d(d),
    .inc(inc), .dec(dec), .sat(sat), .Q(q3), .tc(tc3), .ovf(ovf3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus on the falling edge, record what it must produce,
  // and return just after the rising edge that consumes it.
  task automatic step(input stim_t s, input bit sel3);
    exp_t e;
    @(negedge clk);
    clr = s.clr; load = s.load; inc = s.inc; dec = s.dec; sat = s.sat; d = s.d;
    if (reset_n === 1'b1 && $isunknown({clr, load, inc, dec})) begin
      total++;
      $display("FAIL x_input: control inputs %b, required known", {clr, load, inc, dec});
    end
    e.q = s.q; e.tc = s.tc; e.ovf = s.ovf; e.sel3 = sel3;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t st [4];
    exp_t  e;
    st = '{'{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0}};
    reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) reset_n = 1'b1;
      step(st[k], 1'b0);
      e = sb.pop_front();
      total++;
      if (q1 !== e.q || tc1 !== e.tc || ovf1 !== e.ovf)
        $display("FAIL reset[%0d]: got Q=%h tc=%b ovf=%b, required Q=%h tc=%b ovf=%b",
                 k, q1, tc1, ovf1, e.q, e.tc, e.ovf);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    stim_t st [6];
    exp_t  e;
    st = '{'{1'b0,1'b1,1'b0,1'b0,1'b0,16'hFFFD, 16'hFFFD,1'b0,1'b0},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'hFFFE,1'b0,1'b0},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'hFFFF,1'b0,1'b0},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0000,1'b1,1'b1},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0001,1'b0,1'b1},
           '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0001,1'b0,1'b1}};
    for (int k = 0; k < 6; k++) begin
      step(st[k], 1'b0);
      e = sb.pop_front();
      total++;
      if (q1 !== e.q || tc1 !== e.tc || ovf1 !== e.ovf)
        $display("FAIL wrap[%0d]: got Q=%h tc=%b ovf=%b, required Q=%h tc=%b ovf=%b",
                 k, q1, tc1, ovf1, e.q, e.tc, e.ovf);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    stim_t st [9];
    exp_t  e;
    st = '{'{1'b1,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b1,1'b0,1'b0,1'b1,16'h0002, 16'h0002,1'b0,1'b0},
           '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h0000, 16'h0001,1'b0,1'b0},
           '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h0000, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h0000, 16'h0000,1'b1,1'b1},
           '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h0000, 16'h0000,1'b1,1'b1},
           '{1'b0,1'b0,1'b1,1'b1,1'b1,16'h0000, 16'h0000,1'b0,1'b1},
           '{1'b0,1'b1,1'b0,1'b0,1'b1,16'hFFFF, 16'hFFFF,1'b0,1'b1},
           '{1'b0,1'b0,1'b1,1'b0,1'b1,16'h0000, 16'hFFFF,1'b1,1'b1}};
    for (int k = 0; k < 9; k++) begin
      step(st[k], 1'b0);
      e = sb.pop_front();
      total++;
      if (q1 !== e.q || tc1 !== e.tc || ovf1 !== e.ovf)
        $display("FAIL saturate[%0d]: got Q=%h tc=%b ovf=%b, required Q=%h tc=%b ovf=%b",
                 k, q1, tc1, ovf1, e.q, e.tc, e.ovf);
      else passed++;
    end
  endtask

  task automatic test_priority();
    stim_t st [6];
    exp_t  e;
    st = '{'{1'b1,1'b1,1'b1,1'b0,1'b0,16'h1234, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b1,1'b1,1'b0,1'b0,16'h1234, 16'h1234,1'b0,1'b0},
           '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, 16'h1233,1'b0,1'b0},
           '{1'b0,1'b1,1'b1,1'b0,1'b0,16'hFFFF, 16'hFFFF,1'b0,1'b0},
           '{1'b0,1'b1,1'b1,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, 16'hFFFF,1'b1,1'b1}};
    for (int k = 0; k < 6; k++) begin
      step(st[k], 1'b0);
      e = sb.pop_front();
      total++;
      if (q1 !== e.q || tc1 !== e.tc || ovf1 !== e.ovf)
        $display("FAIL priority[%0d]: got Q=%h tc=%b ovf=%b, required Q=%h tc=%b ovf=%b",
                 k, q1, tc1, ovf1, e.q, e.tc, e.ovf);
      else passed++;
    end
  endtask

  task automatic test_step3();
    stim_t st [8];
    exp_t  e;
    st = '{'{1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b1,1'b0,1'b0,1'b0,16'hFFFC, 16'hFFFC,1'b0,1'b0},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'hFFFF,1'b0,1'b0},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0002,1'b1,1'b1},
           '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, 16'hFFFF,1'b1,1'b1},
           '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h0000, 16'hFFFC,1'b0,1'b1},
           '{1'b0,1'b1,1'b0,1'b0,1'b1,16'h0001, 16'h0001,1'b0,1'b1},
           '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h0000, 16'h0000,1'b1,1'b1}};
    for (int k = 0; k < 8; k++) begin
      step(st[k], 1'b1);
      e = sb.pop_front();
      total++;
      if (q3 !== e.q || tc3 !== e.tc || ovf3 !== e.ovf)
        $display("FAIL step3[%0d]: got Q=%h tc=%b ovf=%b, required Q=%h tc=%b ovf=%b",
                 k, q3, tc3, ovf3, e.q, e.tc, e.ovf);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    stim_t st [8];
    exp_t  e;
    st = '{'{1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b1,1'b0,1'b0,1'b0,16'hFFFF, 16'hFFFF,1'b0,1'b0},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0000,1'b1,1'b1},
           '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0103, 16'h0103,1'b0,1'b1},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0104,1'b0,1'b1},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0000,1'b0,1'b0},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0001,1'b0,1'b0},
           '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0002,1'b0,1'b0}};
    for (int k = 0; k < 8; k++) begin
      if (k == 6) reset_n = 1'b1;
      step(st[k], 1'b0);
      e = sb.pop_front();
      total++;
      if (q1 !== e.q || tc1 !== e.tc || ovf1 !== e.ovf)
        $display("FAIL async_reset[%0d]: got Q=%h tc=%b ovf=%b, required Q=%h tc=%b ovf=%b",
                 k, q1, tc1, ovf1, e.q, e.tc, e.ovf);
      else passed++;
      if (k == 4) begin
        // Assert reset between edges and look before the next rising edge.
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (q1 !== 16'h0000 || tc1 !== 1'b0 || ovf1 !== 1'b0)
          $display("FAIL async_reset_immediate: got Q=%h tc=%b ovf=%b, required Q=0000 tc=0 ovf=0",
                   q1, tc1, ovf1);
        else passed++;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clr = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0; sat = 1'b0; d = '0;
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_step3();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
